// File: rtl/icnd2110_frame_scheduler.sv
// Write-port owner for the output block's double-buffered word memory:
// host writes take priority over the pattern-fill sequencer, and all writes land in the back bank.
// Bank swaps are held back until the output block reports a frame boundary and no fill is running.
module icnd2110_frame_scheduler #(
  parameter int WORD_COUNT = 336,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           host_data,
  input  logic [ADDR_WIDTH-1:0] host_address,
  input  logic                  host_write_strobe,
  input  logic                  host_commit,
  input  logic                  fill_start,
  input  logic [1:0]            fill_mode,
  input  logic [15:0]           fill_value,
  input  logic                  frame_done,
  output logic [15:0]           mem_data,
  output logic [ADDR_WIDTH:0]   mem_address,
  output logic                  mem_write_strobe,
  output logic                  display_bank,
  output logic                  commit_pending,
  output logic                  fill_busy,
  output logic                  host_drop
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(WORD_COUNT - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fill_state_t;

  fill_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [1:0]            mode_q, mode_d;
  logic [15:0]           value_q, value_d;
  logic                  fill_busy_q, fill_busy_d;
  logic                  display_bank_q, display_bank_d;
  logic                  commit_pending_q, commit_pending_d;
  logic [15:0]           mem_data_q, mem_data_d;
  logic [ADDR_WIDTH:0]   mem_address_q, mem_address_d;
  logic                  mem_write_strobe_q, mem_write_strobe_d;
  logic                  host_drop_q, host_drop_d;

  logic [15:0]           fill_data;
  logic                  swap_now;

  // Pattern generator for the current fill index, driven by the latched mode/seed.
  always_comb begin
    fill_data = value_q;
    case (mode_q)
      2'd1:    fill_data = value_q + 16'(idx_q);
      2'd2:    fill_data = idx_q[0] ? ~value_q : value_q;
      default: fill_data = value_q;
    endcase
  end

  // Next-state: write arbitration, fill sequencing and frame-aligned bank swap.
  always_comb begin
    state_d            = state_q;
    idx_d              = idx_q;
    mode_d             = mode_q;
    value_d            = value_q;
    fill_busy_d        = fill_busy_q;
    display_bank_d     = display_bank_q;
    commit_pending_d   = commit_pending_q;
    mem_data_d         = mem_data_q;
    mem_address_d      = mem_address_q;
    mem_write_strobe_d = 1'b0;
    host_drop_d        = 1'b0;

    // A host strobe owns the port for the cycle, even when its address is
    // out of range, so the fill index only advances on host-free cycles.
    if (host_write_strobe) begin
      if (host_address <= LAST_IDX) begin
        mem_write_strobe_d = 1'b1;
        mem_address_d      = {~display_bank_q, host_address};
        mem_data_d         = host_data;
      end else begin
        host_drop_d = 1'b1;
      end
    end else if (state_q == RUN) begin
      mem_write_strobe_d = 1'b1;
      mem_address_d      = {~display_bank_q, idx_q};
      mem_data_d         = fill_data;
      if (idx_q == LAST_IDX) begin
        state_d     = IDLE;
        fill_busy_d = 1'b0;
        idx_d       = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end

    // A start request is only honoured from IDLE.
    if (state_q == IDLE && fill_start) begin
      state_d     = RUN;
      fill_busy_d = 1'b1;
      idx_d       = '0;
      mode_d      = fill_mode;
      value_d     = fill_value;
    end

    // Pending is checked from the register, so a commit arriving together
    // with frame_done waits for the following frame boundary.
    swap_now = frame_done && commit_pending_q && !fill_busy_q;
    if (swap_now) begin
      display_bank_d   = ~display_bank_q;
      commit_pending_d = 1'b0;
    end else if (host_commit) begin
      commit_pending_d = 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= IDLE;
      idx_q              <= '0;
      mode_q             <= '0;
      value_q            <= '0;
      fill_busy_q        <= 1'b0;
      display_bank_q     <= 1'b0;
      commit_pending_q   <= 1'b0;
      mem_data_q         <= '0;
      mem_address_q      <= '0;
      mem_write_strobe_q <= 1'b0;
      host_drop_q        <= 1'b0;
    end else begin
      state_q            <= state_d;
      idx_q              <= idx_d;
      mode_q             <= mode_d;
      value_q            <= value_d;
      fill_busy_q        <= fill_busy_d;
      display_bank_q     <= display_bank_d;
      commit_pending_q   <= commit_pending_d;
      mem_data_q         <= mem_data_d;
      mem_address_q      <= mem_address_d;
      mem_write_strobe_q <= mem_write_strobe_d;
      host_drop_q        <= host_drop_d;
    end
  end

  assign mem_data         = mem_data_q;
  assign mem_address      = mem_address_q;
  assign mem_write_strobe = mem_write_strobe_q;
  assign display_bank     = display_bank_q;
  assign commit_pending   = commit_pending_q;
  assign fill_busy        = fill_busy_q;
  assign host_drop        = host_drop_q;

endmodule

// File: tb/tb_icnd2110_frame_scheduler.sv
// Directed bench for icnd2110_frame_scheduler.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Each task checks its own scenario against hand-derived expectations.
module tb_icnd2110_frame_scheduler;

  localparam int WC = 336;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   host_data;
  logic [AW-1:0] host_address;
  logic          host_write_strobe;
  logic          host_commit;
  logic          fill_start;
  logic [1:0]    fill_mode;
  logic [15:0]   fill_value;
  logic          frame_done;
  logic [15:0]   mem_data;
  logic [AW:0]   mem_address;
  logic          mem_write_strobe;
  logic          display_bank;
  logic          commit_pending;
  logic          fill_busy;
  logic          host_drop;

  int tests_run = 0;
  int tests_failed = 0;

  icnd2110_frame_scheduler #(.WORD_COUNT(WC), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .host_data(host_data), .host_address(host_address),
    .host_write_strobe(host_write_strobe), .host_commit(host_commit),
    .fill_start(fill_start), .fill_mode(fill_mode), .fill_value(fill_value),
    .frame_done(frame_done),
    .mem_data(mem_data), .mem_address(mem_address),
    .mem_write_strobe(mem_write_strobe), .display_bank(display_bank),
    .commit_pending(commit_pending), .fill_busy(fill_busy), .host_drop(host_drop)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] exp_fill(input logic [1:0] mode, input logic [15:0] val, input int idx);
    logic [15:0] r;
    case (mode)
      2'd1:    r = val + 16'(idx);
      2'd2:    r = (idx % 2 == 1) ? ~val : val;
      default: r = val;
    endcase
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    host_data = '0; host_address = '0; host_write_strobe = 1'b0;
    host_commit = 1'b0; fill_start = 1'b0; fill_mode = '0; fill_value = '0;
    frame_done = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tests_run++;
    if ({mem_data, mem_address, mem_write_strobe, display_bank, commit_pending, fill_busy, host_drop} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs got data=%h addr=%h we=%b bank=%b pend=%b busy=%b drop=%b required all zero",
               mem_data, mem_address, mem_write_strobe, display_bank, commit_pending, fill_busy, host_drop);
    end
  endtask

  task automatic test_host_write();
    host_address = 12'd5; host_data = 16'hABCD; host_write_strobe = 1'b1;
    tick();
    host_write_strobe = 1'b0;
    tests_run++;
    if (mem_write_strobe !== 1'b1 || mem_address !== {1'b1, 12'd5} || mem_data !== 16'hABCD || display_bank !== 1'b0) begin
      tests_failed++;
      $display("FAIL host_write got we=%b addr=%h data=%h bank=%b required we=1 addr=1005 data=abcd bank=0",
               mem_write_strobe, mem_address, mem_data, display_bank);
    end
    tick();
    tests_run++;
    if (mem_write_strobe !== 1'b0) begin
      tests_failed++;
      $display("FAIL host_write_single got we=%b required 0", mem_write_strobe);
    end
  endtask

  task automatic test_host_drop();
    host_address = 12'd336; host_data = 16'h1111; host_write_strobe = 1'b1;
    tick();
    host_write_strobe = 1'b0;
    tests_run++;
    if (mem_write_strobe !== 1'b0 || host_drop !== 1'b1) begin
      tests_failed++;
      $display("FAIL host_drop got we=%b drop=%b required we=0 drop=1", mem_write_strobe, host_drop);
    end
    tick();
    tests_run++;
    if (host_drop !== 1'b0 || mem_write_strobe !== 1'b0) begin
      tests_failed++;
      $display("FAIL host_drop_pulse got drop=%b we=%b required 0 0", host_drop, mem_write_strobe);
    end
  endtask

  // Runs one fill, optionally injecting 3 host writes to addr 7 and always
  // pulsing a conflicting fill_start mid-run, which must be ignored.
  task automatic run_fill(input string name, input logic [1:0] mode, input logic [15:0] val,
                          input logic bank, input bit inject, input int exp_busy);
    int  idx = 0;
    int  busy = 0;
    int  hosts = 0;
    bit  host_exp = 0;
    fill_mode = mode; fill_value = val; fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    for (int i = 0; i < 360; i++) begin
      if (host_exp) begin
        tests_run++;
        if (mem_write_strobe !== 1'b1 || mem_address !== {bank, 12'd7} || mem_data !== 16'h5A5A) begin
          tests_failed++;
          $display("FAIL %s host_slot i=%0d got we=%b addr=%h data=%h required we=1 addr=%h data=5a5a",
                   name, i, mem_write_strobe, mem_address, mem_data, {bank, 12'd7});
        end
        hosts++;
      end else if (mem_write_strobe === 1'b1) begin
        tests_run++;
        if (idx >= WC || mem_address !== {bank, 12'(idx)} || mem_data !== exp_fill(mode, val, idx)) begin
          tests_failed++;
          $display("FAIL %s fill_write idx=%0d got addr=%h data=%h required addr=%h data=%h",
                   name, idx, mem_address, mem_data, {bank, 12'(idx)}, exp_fill(mode, val, idx));
        end
        idx++;
      end
      if (fill_busy === 1'b1) busy++;
      host_write_strobe = inject && (i == 20 || i == 21 || i == 200);
      host_address = 12'd7; host_data = 16'h5A5A;
      host_exp = host_write_strobe;
      fill_start = (i == 50);
      fill_mode = ~mode; fill_value = ~val;
      tick();
    end
    host_write_strobe = 1'b0; fill_start = 1'b0;
    tests_run++;
    if (idx != WC || busy != exp_busy || hosts != (inject ? 3 : 0)) begin
      tests_failed++;
      $display("FAIL %s counts got writes=%0d busy=%0d hosts=%0d required %0d %0d %0d",
               name, idx, busy, hosts, WC, exp_busy, inject ? 3 : 0);
    end
  endtask

  task automatic test_fill_ramp();
    run_fill("fill_ramp", 2'd1, 16'h0100, 1'b1, 1'b0, 336);
  endtask

  task automatic test_fill_contended();
    run_fill("fill_contended", 2'd1, 16'h0100, 1'b1, 1'b1, 339);
  endtask

  task automatic test_fill_checker();
    run_fill("fill_checker", 2'd2, 16'h00FF, 1'b1, 1'b0, 336);
  endtask

  task automatic test_commit_swap();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    tests_run++;
    if (display_bank !== 1'b0 || commit_pending !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_frame_done got bank=%b pend=%b required 0 0", display_bank, commit_pending);
    end
    host_commit = 1'b1;
    tick();
    host_commit = 1'b0;
    tests_run++;
    if (commit_pending !== 1'b1 || display_bank !== 1'b0) begin
      tests_failed++;
      $display("FAIL commit_pending got pend=%b bank=%b required 1 0", commit_pending, display_bank);
    end
    for (int i = 0; i < 9; i++) tick();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    tests_run++;
    if (display_bank !== 1'b1 || commit_pending !== 1'b0) begin
      tests_failed++;
      $display("FAIL commit_swap got bank=%b pend=%b required 1 0", display_bank, commit_pending);
    end
    host_address = 12'd0; host_data = 16'h1234; host_write_strobe = 1'b1;
    tick();
    host_write_strobe = 1'b0;
    tests_run++;
    if (mem_write_strobe !== 1'b1 || mem_address !== {1'b0, 12'd0} || mem_data !== 16'h1234) begin
      tests_failed++;
      $display("FAIL post_swap_write got we=%b addr=%h data=%h required 1 0000 1234",
               mem_write_strobe, mem_address, mem_data);
    end
  endtask

  task automatic test_commit_same_cycle();
    host_commit = 1'b1; frame_done = 1'b1;
    tick();
    host_commit = 1'b0; frame_done = 1'b0;
    tests_run++;
    if (commit_pending !== 1'b1 || display_bank !== 1'b1) begin
      tests_failed++;
      $display("FAIL same_cycle_commit got pend=%b bank=%b required 1 1", commit_pending, display_bank);
    end
    tick();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    tests_run++;
    if (commit_pending !== 1'b0 || display_bank !== 1'b0) begin
      tests_failed++;
      $display("FAIL same_cycle_next_frame got pend=%b bank=%b required 0 0", commit_pending, display_bank);
    end
  endtask

  task automatic test_commit_deferred();
    int waited = 0;
    fill_mode = 2'd3; fill_value = 16'hBEEF; fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    host_commit = 1'b1;
    tick();
    host_commit = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    tests_run++;
    if (display_bank !== 1'b0 || commit_pending !== 1'b1 || fill_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL deferred_no_swap got bank=%b pend=%b busy=%b required 0 1 1",
               display_bank, commit_pending, fill_busy);
    end
    while (fill_busy === 1'b1 && waited < 400) begin
      tick();
      waited++;
    end
    tests_run++;
    if (fill_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL deferred_fill_end got busy=%b after %0d cycles required 0", fill_busy, waited);
    end
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    tests_run++;
    if (display_bank !== 1'b1 || commit_pending !== 1'b0) begin
      tests_failed++;
      $display("FAIL deferred_swap got bank=%b pend=%b required 1 0", display_bank, commit_pending);
    end
  endtask

  task automatic test_reset_mid_fill();
    int writes = 0;
    fill_mode = 2'd0; fill_value = 16'h7777; fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++;
    if (fill_busy !== 1'b0 || mem_write_strobe !== 1'b0 || display_bank !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_fill got busy=%b we=%b bank=%b required 0 0 0", fill_busy, mem_write_strobe, display_bank);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mem_write_strobe === 1'b1) writes++;
    end
    tests_run++;
    if (writes != 0) begin
      tests_failed++;
      $display("FAIL reset_mid_fill_writes got %0d writes required 0", writes);
    end
  endtask

  initial begin
    test_reset();
    test_host_write();
    test_host_drop();
    test_fill_ramp();
    test_fill_contended();
    test_fill_checker();
    test_commit_swap();
    test_commit_same_cycle();
    test_commit_deferred();
    test_reset_mid_fill();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/icnd2110_frame_scheduler.md
Name: icnd2110_frame_scheduler

Overview:
- Owns the single write port of the ICND2110 output block's double-buffered word memory.
- Arbitrates that port between host (SPI) word writes and an internal fill/test-pattern sequencer.
- Schedules front/back bank swaps so a swap only happens at a frame boundary reported by the output block.
- All writes target the back bank; the output block reads the bank given by display_bank.

Parameters:
- WORD_COUNT, 336, words per bank (28 chips x 12 outputs).
- ADDR_WIDTH, 12, per-bank word address width; 2^ADDR_WIDTH >= WORD_COUNT.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- host_data  input  16  host write data
- host_address  input  ADDR_WIDTH  host word address within bank
- host_write_strobe  input  1  one-cycle host write request; always accepted or dropped, never stalled
- host_commit  input  1  one-cycle request to swap banks at next frame boundary
- fill_start  input  1  one-cycle request to start a pattern fill of the back bank
- fill_mode  input  2  0=constant, 1=ramp, 2=checkerboard, 3=constant
- fill_value  input  16  fill seed value
- frame_done  input  1  one-cycle pulse from output block at end of frame trailer
- mem_data  output  16  memory write data
- mem_address  output  ADDR_WIDTH+1  {bank, word address}
- mem_write_strobe  output  1  memory write enable
- display_bank  output  1  bank the output block displays
- commit_pending  output  1  swap requested, not yet taken
- fill_busy  output  1  fill sequencer active
- host_drop  output  1  one-cycle pulse: host write discarded

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk.
- Reset values: all outputs 0, display_bank=0, fill FSM IDLE.
- rst mid-fill aborts the fill; no further writes are issued.

Write arbitration:
- Registered outputs; a write request in cycle N appears on the mem_* ports in cycle N+1.
- mem_write_strobe is high for exactly one cycle per write.
- Back bank = ~display_bank, sampled in the accept cycle.
- Host has strict priority. A cycle with host_write_strobe issues the host write; the fill sequencer stalls that cycle and does not advance its index.
- host_address >= WORD_COUNT: no memory write; host_drop=1 in cycle N+1.

Fill FSM (IDLE, RUN):
- IDLE -> RUN on fill_start. At start: latch fill_mode and fill_value, index=0, fill_busy=1 from the next cycle.
- fill_start while RUN is ignored.
- RUN, each non-host cycle: write index with data
  - mode 0/3: fill_value
  - mode 1: fill_value+index, truncated to 16 bits (wraps)
  - mode 2: fill_value if index even, else ~fill_value
- Then index+1.
- After issuing index WORD_COUNT-1: go to IDLE; fill_busy=0 in that same next cycle.
- An uncontended fill takes WORD_COUNT cycles.

Bank swap:
- host_commit sets commit_pending=1. A commit while already pending has no further effect.
- Swap condition: frame_done && commit_pending && !fill_busy. When met, display_bank toggles and commit_pending clears in the next cycle.
- frame_done while fill_busy: swap deferred to the first frame_done after the fill ends.
- host_commit and frame_done in the same cycle with commit_pending=0: pending is set; no swap until the next frame_done.
- A host write accepted in the swap cycle uses the pre-swap back bank.
- Software rule: do not write while commit_pending is set.
- frame_done with no pending commit: no effect.

Test Plan:
- After reset, host write addr 5, data 0xABCD -> one cycle later mem_write_strobe=1, mem_address={1,5}, mem_data=0xABCD; display_bank=0.
- Host write addr 336 -> no mem_write_strobe; host_drop pulse one cycle later.
- fill_start with mode 1, value 0x0100, no host traffic:
  - 336 consecutive writes to {1,0}..{1,335}.
  - Data runs 0x0100..0x024F.
  - fill_busy is high for exactly 336 cycles.
- Same fill with 3 host writes (addr 7) injected mid-fill:
  - Host writes appear in their slots.
  - The fill completes in 339 cycles.
  - Every fill index 0..335 is written exactly once, in order.
- host_commit, then frame_done 10 cycles later -> display_bank=1 and commit_pending=0 on the cycle after frame_done. A following host write to addr 0 goes to {0,0}.
- host_commit during a fill, with frame_done during the fill -> no swap. The next frame_done after fill_busy falls toggles display_bank.
